// File: rtl/popcnt_pkg.sv
// rtl/popcnt_pkg.sv - shared widths and thermometer helpers for popcount_sn_pipe
package popcnt_pkg;

    localparam int MAX_GROUP = 8;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Sorted codes carry their ones from bit 0 upward, so the highest set bit gives the count.
    function automatic logic [3:0] therm2bin(input logic [MAX_GROUP-1:0] code);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_GROUP; i++) begin
            if (code[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/sn_sort_group.sv
// rtl/sn_sort_group.sv - odd-even transposition sorting network on single bits
module sn_sort_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] din,
    output logic [GROUP-1:0] dout
);

    logic [GROUP:0][GROUP-1:0] st;

    assign st[0] = din;

    // GROUP alternating compare-exchange layers fully sort GROUP elements; OR moves ones toward bit 0.
    for (genvar s = 0; s < GROUP; s++) begin : g_stage
        for (genvar i = 0; i < GROUP; i++) begin : g_bit
            if ((i % 2) == (s % 2) && (i + 1) < GROUP) begin : g_hi
                assign st[s+1][i] = st[s][i] | st[s][i+1];
            end else if (i >= 1 && ((i - 1) % 2) == (s % 2)) begin : g_lo
                assign st[s+1][i] = st[s][i-1] & st[s][i];
            end else begin : g_pass
                assign st[s+1][i] = st[s][i];
            end
        end
    end

    assign dout = st[GROUP];

endmodule

// File: rtl/popcount_sn_pipe.sv
// rtl/popcount_sn_pipe.sv - two-stage sorting-network ones counter with burst accumulate
module popcount_sn_pipe
    import popcnt_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int GROUP = 4,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_acc_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic              out_sat
);

    localparam int CNT_W = cnt_w(N_IN);
    localparam int NG    = (N_IN + GROUP - 1) / GROUP;
    localparam int PW    = NG * GROUP;

    logic [PW-1:0]    padded;
    logic [PW-1:0]    sorted;
    logic [PW-1:0]    s1_therm;
    logic             s1_valid;
    logic             s1_mode;
    logic             s1_last;
    logic             s2_ready;
    logic             s1_adv;
    logic [CNT_W-1:0] s2_cnt;
    logic [ACC_W-1:0] acc;
    logic             sticky;
    logic [ACC_W:0]   acc_sum;
    logic             acc_ovf;
    logic [ACC_W-1:0] acc_sat;

    assign padded = PW'(in_data);

    for (genvar g = 0; g < NG; g++) begin : g_grp
        sn_sort_group #(.GROUP(GROUP)) u_sort (
            .din  (padded[g*GROUP +: GROUP]),
            .dout (sorted[g*GROUP +: GROUP])
        );
    end

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign s1_adv   = s1_valid && s2_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_therm <= '0;
            s1_mode  <= 1'b0;
            s1_last  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_therm <= sorted;
                s1_mode  <= cfg_acc_mode;
                s1_last  <= in_last;
            end
        end
    end

    always_comb begin
        logic [MAX_GROUP-1:0] code;
        code   = '0;
        s2_cnt = '0;
        for (int g = 0; g < NG; g++) begin
            code = '0;
            code[GROUP-1:0] = s1_therm[g*GROUP +: GROUP];
            s2_cnt = s2_cnt + CNT_W'(therm2bin(code));
        end
    end

    assign acc_sum = {1'b0, acc} + (ACC_W+1)'(s2_cnt);
    assign acc_ovf = acc_sum[ACC_W];
    assign acc_sat = acc_ovf ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

    // Non-last accumulate beats retire into acc without touching the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
            acc       <= '0;
            sticky    <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (s1_adv) begin
                if (!s1_mode) begin
                    out_valid <= 1'b1;
                    out_count <= ACC_W'(s2_cnt);
                    out_sat   <= 1'b0;
                end else if (!s1_last) begin
                    acc    <= acc_sat;
                    sticky <= sticky | acc_ovf;
                end else begin
                    out_valid <= 1'b1;
                    out_count <= acc_sat;
                    out_sat   <= sticky | acc_ovf;
                    acc       <= '0;
                    sticky    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_sn_pipe.sv
// tb/tb_popcount_sn_pipe.sv - directed and randomized checks for popcount_sn_pipe
module tb_popcount_sn_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        mode_a, iv_a, ir_a, last_a, ov_a, or_a, sat_a;
    logic [6:0]  d_a;
    logic [15:0] cnt_a;
    logic        mode_b, iv_b, ir_b, last_b, ov_b, or_b, sat_b;
    logic [6:0]  d_b;
    logic [3:0]  cnt_b;
    logic        mode_c, iv_c, ir_c, last_c, ov_c, or_c, sat_c;
    logic [15:0] d_c;
    logic [15:0] cnt_c;
    logic        mode_d, iv_d, ir_d, last_d, ov_d, or_d, sat_d;
    logic [8:0]  d_d;
    logic [15:0] cnt_d;

    popcount_sn_pipe #(.N_IN(7), .GROUP(4), .ACC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_acc_mode(mode_a), .in_valid(iv_a), .in_ready(ir_a),
        .in_data(d_a), .in_last(last_a), .out_valid(ov_a), .out_ready(or_a),
        .out_count(cnt_a), .out_sat(sat_a));
    popcount_sn_pipe #(.N_IN(7), .GROUP(4), .ACC_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_acc_mode(mode_b), .in_valid(iv_b), .in_ready(ir_b),
        .in_data(d_b), .in_last(last_b), .out_valid(ov_b), .out_ready(or_b),
        .out_count(cnt_b), .out_sat(sat_b));
    popcount_sn_pipe #(.N_IN(16), .GROUP(4), .ACC_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .cfg_acc_mode(mode_c), .in_valid(iv_c), .in_ready(ir_c),
        .in_data(d_c), .in_last(last_c), .out_valid(ov_c), .out_ready(or_c),
        .out_count(cnt_c), .out_sat(sat_c));
    popcount_sn_pipe #(.N_IN(9), .GROUP(4), .ACC_W(16)) dut_d (
        .clk(clk), .rst_n(rst_n), .cfg_acc_mode(mode_d), .in_valid(iv_d), .in_ready(ir_d),
        .in_data(d_d), .in_last(last_d), .out_valid(ov_d), .out_ready(or_d),
        .out_count(cnt_d), .out_sat(sat_d));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ov_a, ov_b, ov_c, ov_d} !== 4'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0000", {ov_a, ov_b, ov_c, ov_d});
        end
        checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 4'd0 || cnt_c !== 16'd0 || cnt_d !== 16'd0) begin
            errors++; $display("FAIL reset_count got %0d/%0d/%0d/%0d exp 0", cnt_a, cnt_b, cnt_c, cnt_d);
        end
        checks++;
        if ({sat_a, sat_b, sat_c, sat_d} !== 4'b0) begin
            errors++; $display("FAIL reset_sat got %b exp 0000", {sat_a, sat_b, sat_c, sat_d});
        end
        checks++;
        if ({ir_a, ir_b, ir_c, ir_d} !== 4'b1111) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1111", {ir_a, ir_b, ir_c, ir_d});
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_count();
        mode_a = 1'b0; or_a = 1'b1; last_a = 1'b0;
        iv_a = 1'b1; d_a = 7'b0111011;
        step();
        checks++;
        if (ov_a !== 1'b0) begin errors++; $display("FAIL count_latency got valid=%b exp 0", ov_a); end
        d_a = 7'h7F;
        step();
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd5) begin
            errors++; $display("FAIL count_0111011 got valid=%b cnt=%0d exp 1/5", ov_a, cnt_a);
        end
        d_a = 7'h00;
        step();
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd7) begin
            errors++; $display("FAIL count_7f got valid=%b cnt=%0d exp 1/7", ov_a, cnt_a);
        end
        iv_a = 1'b0;
        step();
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd0) begin
            errors++; $display("FAIL count_00 got valid=%b cnt=%0d exp 1/0", ov_a, cnt_a);
        end
        step();
        checks++;
        if (ov_a !== 1'b0) begin errors++; $display("FAIL count_idle got valid=%b exp 0", ov_a); end
    endtask

    task automatic test_backpressure();
        mode_a = 1'b0; or_a = 1'b0; iv_a = 1'b1; d_a = 7'h01;
        step();
        d_a = 7'h03;
        step();
        d_a = 7'h07;
        checks++;
        if (ir_a !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", ir_a); end
        step(); step();
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd1 || ir_a !== 1'b0) begin
            errors++; $display("FAIL bp_hold got valid=%b cnt=%0d rdy=%b exp 1/1/0", ov_a, cnt_a, ir_a);
        end
        or_a = 1'b1;
        #1;
        checks++;
        if (ir_a !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", ir_a); end
        step();
        iv_a = 1'b0;
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd2) begin
            errors++; $display("FAIL bp_second got valid=%b cnt=%0d exp 1/2", ov_a, cnt_a);
        end
        step();
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd3) begin
            errors++; $display("FAIL bp_third got valid=%b cnt=%0d exp 1/3", ov_a, cnt_a);
        end
        step();
        checks++;
        if (ov_a !== 1'b0) begin errors++; $display("FAIL bp_no_dup got valid=%b exp 0", ov_a); end
    endtask

    task automatic test_accumulate();
        logic [6:0] v [3];
        int nout, got, gsat;
        v[0] = 7'h7F; v[1] = 7'h01; v[2] = 7'h0F;
        nout = 0; got = -1; gsat = -1;
        mode_a = 1'b1; or_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv_a = 1'b1; d_a = v[k]; last_a = (k == 2);
            if (ov_a) begin nout++; got = int'(cnt_a); gsat = int'(sat_a); end
            step();
        end
        iv_a = 1'b0; last_a = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ov_a) begin nout++; got = int'(cnt_a); gsat = int'(sat_a); end
            step();
        end
        checks++;
        if (nout != 1) begin errors++; $display("FAIL acc_num_outputs got %0d exp 1", nout); end
        checks++;
        if (got != 12 || gsat != 0) begin
            errors++; $display("FAIL acc_burst got cnt=%0d sat=%0d exp 12/0", got, gsat);
        end
        iv_a = 1'b1; d_a = 7'h05; last_a = 1'b1;
        step();
        iv_a = 1'b0; last_a = 1'b0;
        step();
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd2 || sat_a !== 1'b0) begin
            errors++; $display("FAIL acc_fresh_burst got valid=%b cnt=%0d sat=%b exp 1/2/0", ov_a, cnt_a, sat_a);
        end
        step();
    endtask

    task automatic test_saturation();
        logic [6:0] v [3];
        v[0] = 7'h7F; v[1] = 7'h7F; v[2] = 7'h03;
        mode_b = 1'b1; or_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv_b = 1'b1; d_b = v[k]; last_b = (k == 2);
            step();
        end
        iv_b = 1'b1; d_b = 7'h01; last_b = 1'b1;
        step();
        iv_b = 1'b0; last_b = 1'b0;
        checks++;
        if (ov_b !== 1'b1 || cnt_b !== 4'd15 || sat_b !== 1'b1) begin
            errors++; $display("FAIL sat_clamp got valid=%b cnt=%0d sat=%b exp 1/15/1", ov_b, cnt_b, sat_b);
        end
        step();
        checks++;
        if (ov_b !== 1'b1 || cnt_b !== 4'd1 || sat_b !== 1'b0) begin
            errors++; $display("FAIL sat_next_burst got valid=%b cnt=%0d sat=%b exp 1/1/0", ov_b, cnt_b, sat_b);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        mode_a = 1'b1; or_a = 1'b1;
        iv_a = 1'b1; d_a = 7'h7F; last_a = 1'b0;
        step();
        iv_a = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov_a !== 1'b0 || cnt_a !== 16'd0 || sat_a !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got valid=%b cnt=%0d sat=%b exp 0/0/0", ov_a, cnt_a, sat_a);
        end
        step();
        rst_n = 1'b1;
        step();
        iv_a = 1'b1; d_a = 7'h03; last_a = 1'b1;
        step();
        iv_a = 1'b0; last_a = 1'b0;
        step();
        checks++;
        if (ov_a !== 1'b1 || cnt_a !== 16'd2 || sat_a !== 1'b0) begin
            errors++; $display("FAIL rst_mid_result got valid=%b cnt=%0d sat=%b exp 1/2/0", ov_a, cnt_a, sat_a);
        end
        step();
    endtask

    task automatic test_sweep();
        int qc[$];
        int qd[$];
        logic pend_c, pend_d;
        int exp_v;
        pend_c = 1'b0; pend_d = 1'b0;
        mode_c = 1'b0; mode_d = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            or_c = ($urandom_range(0, 3) != 0);
            or_d = ($urandom_range(0, 1) != 0);
            if (!pend_c) begin
                iv_c = (cyc < 360) && ($urandom_range(0, 3) != 0);
                d_c = 16'($urandom); last_c = 1'($urandom);
            end
            if (!pend_d) begin
                iv_d = (cyc < 360) && ($urandom_range(0, 2) != 0);
                d_d = 9'($urandom); last_d = 1'($urandom);
            end
            #1;
            if (iv_c && ir_c) qc.push_back($countones(d_c));
            if (iv_d && ir_d) qd.push_back($countones(d_d));
            if (ov_c && or_c) begin
                exp_v = (qc.size() > 0) ? qc.pop_front() : -1;
                checks++;
                if (int'(cnt_c) != exp_v || sat_c !== 1'b0) begin
                    errors++; $display("FAIL sweep16 got cnt=%0d sat=%b exp %0d/0", cnt_c, sat_c, exp_v);
                end
            end
            if (ov_d && or_d) begin
                exp_v = (qd.size() > 0) ? qd.pop_front() : -1;
                checks++;
                if (int'(cnt_d) != exp_v || sat_d !== 1'b0) begin
                    errors++; $display("FAIL sweep9 got cnt=%0d sat=%b exp %0d/0", cnt_d, sat_d, exp_v);
                end
            end
            pend_c = iv_c && !ir_c;
            pend_d = iv_d && !ir_d;
            step();
        end
        checks++;
        if (qc.size() != 0 || qd.size() != 0) begin
            errors++; $display("FAIL sweep_drain got pending %0d/%0d exp 0/0", qc.size(), qd.size());
        end
        iv_c = 1'b0; iv_d = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        mode_a = 0; iv_a = 0; d_a = '0; last_a = 0; or_a = 1;
        mode_b = 0; iv_b = 0; d_b = '0; last_b = 0; or_b = 1;
        mode_c = 0; iv_c = 0; d_c = '0; last_c = 0; or_c = 1;
        mode_d = 0; iv_d = 0; d_d = '0; last_d = 0; or_d = 1;
        test_reset();
        test_count();
        test_backpressure();
        test_accumulate();
        test_saturation();
        test_reset_mid_burst();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
